// File: rtl/async_rd_ctrl.sv
// Read-side controller of a dual-clock FIFO: gray read pointer, registered empty/count,
// 1-cycle-latency memory reads feeding a 2-entry first-word-fall-through output buffer.
module async_rd_ctrl #(
  parameter  int DEPTH  = 4,
  parameter  int DWIDTH = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  input  logic [AW:0]       wr_ptr_rsync,
  output logic              rd_mem_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [DWIDTH-1:0] rd_mem_data,
  output logic [AW:0]       rd_ptr,
  output logic              rd_empty,
  output logic [AW:0]       fifo_cnt_rd_synced,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  logic [AW:0]       rd_ptr_bin_q, rd_ptr_bin_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              rd_empty_q, rd_empty_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q;
  logic [DWIDTH-1:0] head_q, head_d;
  logic [DWIDTH-1:0] skid_q, skid_d;

  logic [AW:0]       wr_bin;
  logic              pop;
  logic              rd_en;
  logic [1:0]        occ_after_pop;
  logic [2:0]        occ_committed;

  // Each binary bit is the XOR of all gray bits at and above it.
  always_comb begin
    wr_bin = '0;
    for (int i = 0; i <= AW; i++) begin
      wr_bin[i] = ^(wr_ptr_rsync >> i);
    end
  end

  assign m_valid = (occ_q != 2'd0);
  assign pop     = m_valid & m_ready;

  // Words held plus the one in flight, after this cycle's pop; a new read only
  // issues while a slot is guaranteed free when its data returns.
  assign occ_committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en         = ~rd_empty_q & (occ_committed < 3'd2);

  assign rd_mem_en          = rd_en;
  assign rd_addr            = rd_ptr_bin_q[AW-1:0];
  assign rd_ptr             = rd_ptr_q;
  assign rd_empty           = rd_empty_q;
  assign fifo_cnt_rd_synced = cnt_q;
  assign m_data             = head_q;

  // NOTE: every variable assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    rd_ptr_bin_d = rd_ptr_bin_q + {{AW{1'b0}}, rd_en};
    rd_ptr_d     = rd_ptr_bin_d ^ (rd_ptr_bin_d >> 1);
    rd_empty_d   = (rd_ptr_bin_d == wr_bin);
    cnt_d        = wr_bin - rd_ptr_bin_d;

    head_d        = head_q;
    skid_d        = skid_q;
    occ_after_pop = occ_q - {1'b0, pop};
    if (pop && (occ_q == 2'd2)) begin
      head_d = skid_q;
    end
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) begin
        head_d = rd_mem_data;
      end else begin
        skid_d = rd_mem_data;
      end
    end
    occ_d = occ_after_pop + {1'b0, inflight_q};
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      rd_ptr_bin_q <= '0;
      rd_ptr_q     <= '0;
      rd_empty_q   <= 1'b1;
      cnt_q        <= '0;
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      head_q       <= '0;
      skid_q       <= '0;
    end else begin
      rd_ptr_bin_q <= rd_ptr_bin_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_empty_q   <= rd_empty_d;
      cnt_q        <= cnt_d;
      occ_q        <= occ_d;
      inflight_q   <= rd_en;
      head_q       <= head_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: tb/tb_async_rd_ctrl.sv
// Bench for async_rd_ctrl: a behavioural write side and memory, a scoreboard of
// written words checked by an independent monitor, directed scenarios and random traffic.
module tb_async_rd_ctrl;
  localparam int DEPTH  = 4;
  localparam int DWIDTH = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int MOD    = 1 << PW;

  logic              rd_clk = 1'b0;
  logic              rst_n  = 1'b0;
  logic [AW:0]       wr_ptr_rsync = '0;
  logic              rd_mem_en;
  logic [AW-1:0]     rd_addr;
  logic [DWIDTH-1:0] rd_mem_data = '0;
  logic [AW:0]       rd_ptr;
  logic              rd_empty;
  logic [AW:0]       fifo_cnt_rd_synced;
  logic [DWIDTH-1:0] m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;

  async_rd_ctrl #(.DEPTH(DEPTH), .DWIDTH(DWIDTH)) dut (
    .rd_clk            (rd_clk),
    .rst_n             (rst_n),
    .wr_ptr_rsync      (wr_ptr_rsync),
    .rd_mem_en         (rd_mem_en),
    .rd_addr           (rd_addr),
    .rd_mem_data       (rd_mem_data),
    .rd_ptr            (rd_ptr),
    .rd_empty          (rd_empty),
    .fifo_cnt_rd_synced(fifo_cnt_rd_synced),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready)
  );

  always #5 rd_clk = ~rd_clk;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] exp_q [$];
  int                wbin = 0;
  int                total = 0;
  int                bad = 0;
  bit                mon_on = 1'b0;

  // Memory with a 1-cycle read latency.
  always @(posedge rd_clk) begin
    if (rd_mem_en) rd_mem_data <= mem[rd_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW:0] to_gray(input int b);
    logic [AW:0] x;
    x = PW'(b);
    return x ^ (x >> 1);
  endfunction

  // Decode by searching for the binary value whose gray code matches.
  function automatic int g2b(input logic [AW:0] g);
    for (int b = 0; b < MOD; b++) begin
      if (to_gray(b) == g) return b;
    end
    return -1;
  endfunction

  function automatic int used_words();
    return ((wbin % MOD) - g2b(rd_ptr) + MOD) % MOD;
  endfunction

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic write_word();
    logic [DWIDTH-1:0] w;
    w = $urandom;
    mem[wbin % DEPTH] = w;
    exp_q.push_back(w);
    wbin++;
    wr_ptr_rsync = to_gray(wbin % MOD);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    wbin = 0;
    wr_ptr_rsync = '0;
    repeat (n) write_word();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || m_valid) && c < budget) begin
      tick();
      c++;
    end
    check(name, exp_q.size(), 0);
    check("drain_idle", m_valid, 1'b0);
  endtask

  // Monitor: scoreboard pops plus pointer/count/hold properties, every negedge.
  bit                prev_rst_n = 1'b0;
  int                prev_wbin = 0;
  int                prev_ptr_bin = 0;
  bit                prev_en = 1'b0;
  bit                prev_hold = 1'b0;
  logic [DWIDTH-1:0] prev_data = '0;

  always @(negedge rd_clk) begin
    int cnt_exp;
    int pb;
    if (mon_on) begin
      pb = g2b(rd_ptr);
      if (!prev_rst_n) begin
        check("rst_empty", rd_empty, 1'b1);
        check("rst_valid", m_valid, 1'b0);
        check("rst_ptr", rd_ptr, 0);
        check("rst_cnt", fifo_cnt_rd_synced, 0);
        check("rst_en", rd_mem_en, 1'b0);
        check("rst_addr", rd_addr, 0);
        check("rst_data", m_data, 0);
      end else begin
        cnt_exp = (prev_wbin - pb + MOD) % MOD;
        check("cnt", fifo_cnt_rd_synced, cnt_exp);
        check("empty", rd_empty, cnt_exp == 0);
        check("ptr_step", (pb - prev_ptr_bin + MOD) % MOD, prev_en);
        if (prev_hold) begin
          check("hold_valid", m_valid, 1'b1);
          check("hold_data", m_data, prev_data);
        end
      end
      check("cnt_range", fifo_cnt_rd_synced <= DEPTH, 1'b1);
      check("addr_ptr", rd_addr, pb % DEPTH);
      check("en_not_empty", rd_mem_en & rd_empty, 1'b0);
      check("occ_le_2", dut.occ_q <= 2'd2, 1'b1);
      if (m_valid && m_ready) begin
        check("pop_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("data", m_data, exp_q.pop_front());
      end
      prev_rst_n   = rst_n;
      prev_wbin    = g2b(wr_ptr_rsync);
      prev_ptr_bin = pb;
      prev_en      = rd_mem_en;
      prev_hold    = m_valid && !m_ready;
      prev_data    = m_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DWIDTH-1:0] w0;
    int n;
    bit found;

    // Reset with four words already visible, then stream them out.
    tick();
    mon_on = 1'b1;
    repeat (4) write_word();
    for (int k = 0; k < 3; k++) begin
      @(negedge rd_clk);
      check("rsthold_empty", rd_empty, 1'b1);
      check("rsthold_valid", m_valid, 1'b0);
      check("rsthold_ptr", rd_ptr, 0);
      check("rsthold_cnt", fifo_cnt_rd_synced, 0);
      check("rsthold_en", rd_mem_en, 1'b0);
      tick();
    end
    rst_n   = 1'b1;
    m_ready = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) begin
      @(negedge rd_clk);
      if (k == 0) check("rel_empty", rd_empty, 1'b0);
      check("stream_en", rd_mem_en, k < 4);
      if (k < 4) check("stream_addr", rd_addr, k);
      check("stream_cnt", fifo_cnt_rd_synced, (k <= 4) ? 4 - k : 0);
      check("stream_valid", m_valid, (k >= 2) && (k <= 5));
      tick();
    end
    wait_drain("stream_drain", 10);

    // Single word.
    do_reset(0);
    m_ready = 1'b1;
    tick();
    write_word();
    w0 = exp_q[0];
    @(negedge rd_clk);
    check("single_en_t", rd_mem_en, 1'b0);
    tick();
    @(negedge rd_clk);
    check("single_en_t1", rd_mem_en, 1'b1);
    check("single_addr_t1", rd_addr, 0);
    tick();
    @(negedge rd_clk);
    check("single_ptr_t2", rd_ptr, 3'b001);
    check("single_empty_t2", rd_empty, 1'b1);
    tick();
    @(negedge rd_clk);
    check("single_valid_t3", m_valid, 1'b1);
    check("single_data_t3", m_data, w0);
    tick();
    @(negedge rd_clk);
    check("single_valid_t4", m_valid, 1'b0);

    // Backpressure: only two reads may issue, then release.
    m_ready = 1'b0;
    do_reset(4);
    w0 = exp_q[0];
    n  = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge rd_clk);
      if (rd_mem_en) n++;
      tick();
    end
    check("bp_reads", n, 2);
    check("bp_occ", dut.occ_q, 2);
    check("bp_ptr", rd_ptr, 3'b011);
    check("bp_cnt", fifo_cnt_rd_synced, 2);
    check("bp_valid", m_valid, 1'b1);
    check("bp_head", m_data, w0);
    m_ready = 1'b1;
    wait_drain("bp_drain", 12);

    // Toggling consumer.
    m_ready = 1'b0;
    do_reset(4);
    for (int k = 0; k < 24; k++) begin
      m_ready = ~m_ready;
      tick();
    end
    check("toggle_delivered", exp_q.size(), 0);

    // Pointer wrap from binary 6.
    do_reset(0);
    m_ready = 1'b1;
    tick();
    repeat (4) write_word();
    wait_drain("wrap_pre1", 30);
    repeat (2) write_word();
    wait_drain("wrap_pre2", 30);
    tick();
    check("wrap_start", g2b(rd_ptr), 6);
    repeat (4) write_word();
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge rd_clk);
      if (rd_mem_en) begin
        check("wrap_addr", rd_addr, (6 + n) % DEPTH);
        check("wrap_ptr", rd_ptr, to_gray((6 + n) % MOD));
        n++;
      end
      tick();
    end
    check("wrap_reads", n, 4);
    check("wrap_empty", rd_empty, 1'b1);
    wait_drain("wrap_drain", 20);

    // Reset while a read is in flight and one word is buffered.
    m_ready = 1'b1;
    do_reset(4);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      tick();
      if (rd_mem_en && m_valid && dut.occ_q == 2'd1) found = 1'b1;
    end
    check("mid_found", found, 1'b1);
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    wbin = 0;
    wr_ptr_rsync = '0;
    @(negedge rd_clk);
    check("mid_valid", m_valid, 1'b0);
    check("mid_empty", rd_empty, 1'b1);
    check("mid_ptr", rd_ptr, 0);
    check("mid_addr", rd_addr, 0);
    check("mid_en", rd_mem_en, 1'b0);
    check("mid_data", m_data, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge rd_clk);
      check("mid_discard", m_valid, 1'b0);
      tick();
    end

    // Random traffic and backpressure.
    do_reset(0);
    for (int c = 0; c < 3000; c++) begin
      tick();
      m_ready = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 2; j++) begin
        if (used_words() < DEPTH && $urandom_range(0, 1) == 1) write_word();
      end
    end
    m_ready = 1'b1;
    wait_drain("rand_drain", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
